// File: rtl/shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_pkg : mode/state encodings and effective-amount helper          |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package shift_pkg;

  localparam logic [2:0] MODE_SLL  = 3'd0;
  localparam logic [2:0] MODE_SRL  = 3'd1;
  localparam logic [2:0] MODE_SRA  = 3'd2;
  localparam logic [2:0] MODE_ROL  = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_PASS = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int unsigned eff_amount(input logic [2:0] mode,
                                             input int unsigned amt,
                                             input int unsigned width);
    int unsigned eff;
    eff = 0;
    if (mode < MODE_PASS) begin
      case (mode)
        MODE_SLL, MODE_SRL: eff = (amt > width) ? width : amt;
        MODE_SRA:           eff = (amt > width - 1) ? width - 1 : amt;
        // rotates wrap; width is a power of two so masking is the modulo
        default:            eff = amt & (width - 1);
      endcase
    end
    return eff;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_step : combinational single step, shifts/rotates by 0..STEP     |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int KW    = 5
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_mode,
  input  logic [KW-1:0]    i_k,
  output logic [WIDTH-1:0] o_data
);

  localparam logic [KW-1:0] C_STEP  = KW'(STEP);
  localparam logic [KW-1:0] C_WIDTH = KW'(WIDTH);

  logic [KW-1:0] w_k;
  logic [KW-1:0] w_kc;

  assign w_k  = (i_k > C_STEP) ? C_STEP : i_k;
  // complementary distance for rotates; k=0 gives a full-width shift, i.e. 0
  assign w_kc = C_WIDTH - w_k;

  always_comb begin
    o_data = i_data;
    case (i_mode)
      MODE_SLL: o_data = i_data << w_k;
      MODE_SRL: o_data = i_data >> w_k;
      MODE_SRA: o_data = $unsigned($signed(i_data) >>> w_k);
      MODE_ROL: o_data = (i_data << w_k) | (i_data >> w_kc);
      MODE_ROR: o_data = (i_data >> w_k) | (i_data << w_kc);
      default:  o_data = i_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/iterative_shift_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iterative_shift_unit : multi-cycle shifter/rotator with imm extenders |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
module iterative_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int IMM_W = 12,
  parameter int AMT_W = 5
) (
  input  logic             CLK,
  input  logic             CtrlRst,
  input  logic             Start,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] ShifterIn,
  input  logic [AMT_W-1:0] ShiftAmt,
  input  logic [IMM_W-1:0] Imm,
  output logic [WIDTH-1:0] ShifterOut,
  output logic [WIDTH-1:0] ZeroExtOut,
  output logic [WIDTH-1:0] SignExtOut,
  output logic             Ready,
  output logic             Done
);

  localparam logic [AMT_W-1:0] C_STEP = AMT_W'(STEP);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_step_out;
  logic [2:0]       r_mode;
  logic [AMT_W-1:0] r_rem;
  logic [AMT_W-1:0] w_eff;
  logic [AMT_W-1:0] w_k;
  logic             w_accept;
  logic             w_last;

  assign w_eff    = AMT_W'(eff_amount(Mode, 32'(ShiftAmt), 32'(WIDTH)));
  assign w_k      = (r_rem > C_STEP) ? C_STEP : r_rem;
  assign w_last   = (r_state == ST_SHIFT) && (r_rem == w_k);
  assign w_accept = Start && Ready;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (AMT_W)
  ) u_step (
    .i_data (r_work),
    .i_mode (r_mode),
    .i_k    (w_k),
    .o_data (w_step_out)
  );

  always_ff @(posedge CLK) begin
    if (!CtrlRst) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) w_next_state = (w_eff != '0) ? ST_SHIFT : ST_DONE;
        else          w_next_state = ST_IDLE;
      end
      ST_SHIFT: w_next_state = w_last ? ST_DONE : ST_SHIFT;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    Ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
    Done  = (r_state == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!CtrlRst) begin
      r_work     <= '0;
      r_mode     <= '0;
      r_rem      <= '0;
      ShifterOut <= '0;
      ZeroExtOut <= '0;
      SignExtOut <= '0;
    end else if (w_accept) begin
      r_work     <= ShifterIn;
      r_mode     <= Mode;
      r_rem      <= w_eff;
      ZeroExtOut <= WIDTH'(Imm);
      SignExtOut <= {{(WIDTH-IMM_W){Imm[IMM_W-1]}}, Imm};
      // zero-distance ops enter DONE straight from accept
      if (w_eff == '0) ShifterOut <= ShifterIn;
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_step_out;
      r_rem  <= r_rem - w_k;
      if (w_last) ShifterOut <= w_step_out;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iterative_shift_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_iterative_shift_unit : randomized bench against arithmetic model   |
// | Revision                : 1.0                                         |
// +----------------------------------------------------------------------+
module tb_iterative_shift_unit;

  localparam int WIDTH = 16;
  localparam int STEP  = 4;
  localparam int IMM_W = 12;
  localparam int AMT_W = 5;

  logic             CLK = 1'b0;
  logic             CtrlRst = 1'b0;
  logic             Start = 1'b0;
  logic [2:0]       Mode = 3'd0;
  logic [WIDTH-1:0] ShifterIn = '0;
  logic [AMT_W-1:0] ShiftAmt = '0;
  logic [IMM_W-1:0] Imm = '0;
  logic [WIDTH-1:0] ShifterOut;
  logic [WIDTH-1:0] ZeroExtOut;
  logic [WIDTH-1:0] SignExtOut;
  logic             Ready;
  logic             Done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  iterative_shift_unit #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .IMM_W (IMM_W),
    .AMT_W (AMT_W)
  ) dut (
    .CLK        (CLK),
    .CtrlRst    (CtrlRst),
    .Start      (Start),
    .Mode       (Mode),
    .ShifterIn  (ShifterIn),
    .ShiftAmt   (ShiftAmt),
    .Imm        (Imm),
    .ShifterOut (ShifterOut),
    .ZeroExtOut (ZeroExtOut),
    .SignExtOut (SignExtOut),
    .Ready      (Ready),
    .Done       (Done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_eff(input int m, input int a);
    case (m)
      0, 1:    return (a > 16) ? 16 : a;
      2:       return (a > 15) ? 15 : a;
      3, 4:    return a % 16;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] ref_res(input int m, input int unsigned x, input int e);
    int unsigned r;
    int sx;
    case (m)
      0: r = x << e;
      1: r = x >> e;
      2: begin
        sx = (x >= 32768) ? int'(x) - 65536 : int'(x);
        r  = int'(sx >>> e);
      end
      3: r = (x << e) | (x >> (16 - e));
      4: r = (x >> e) | (x << (16 - e));
      default: r = x;
    endcase
    return r[15:0];
  endfunction

  task automatic wait_done(input string tag, output int c);
    c = 1;
    while (!Done && c < 20) begin
      chk({tag, "_busy"}, {31'd0, Ready}, 32'd0);
      @(posedge CLK); #1;
      c++;
    end
    chk({tag, "_done"}, {31'd0, Done}, 32'd1);
  endtask

  task automatic run_op(input logic [2:0] m, input logic [15:0] x, input logic [4:0] a,
                        input logic [11:0] im, input bit poke);
    int e, lat, c;
    logic [15:0] exp_res, prev, exp_sx;
    e       = ref_eff(int'(m), int'(a));
    exp_res = ref_res(int'(m), 32'(x), e);
    lat     = (e + STEP - 1) / STEP + 1;
    exp_sx  = im[11] ? 16'(32'(im) + 32'hF000) : 16'(im);
    c = 0;
    @(negedge CLK);
    while (!Ready && c < 30) begin
      @(negedge CLK);
      c++;
    end
    chk("ready_wait", {31'd0, Ready}, 32'd1);
    Start = 1'b1; Mode = m; ShifterIn = x; ShiftAmt = a; Imm = im;
    prev = ShifterOut;
    @(posedge CLK); #1;
    Start = 1'b0;
    c = 1;
    while (!Done && c < 20) begin
      chk("hold", 32'(ShifterOut), 32'(prev));
      chk("busy", {31'd0, Ready}, 32'd0);
      if (poke && c == 1) begin
        Start = 1'b1; ShifterIn = ~x; Mode = m ^ 3'd1; ShiftAmt = ~a; Imm = ~im;
      end
      @(posedge CLK); #1;
      Start = 1'b0;
      c++;
    end
    chk("done_seen", {31'd0, Done}, 32'd1);
    chk("latency", 32'(c), 32'(lat));
    chk("result", 32'(ShifterOut), 32'(exp_res));
    chk("zext", 32'(ZeroExtOut), 32'(im));
    chk("sext", 32'(SignExtOut), 32'(exp_sx));
    chk("ready_in_done", {31'd0, Ready}, 32'd1);
  endtask

  initial begin
    int c;
    logic [2:0] rm;

    CtrlRst = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out", 32'(ShifterOut), 32'd0);
    chk("rst_zext", 32'(ZeroExtOut), 32'd0);
    chk("rst_sext", 32'(SignExtOut), 32'd0);
    chk("rst_ready", {31'd0, Ready}, 32'd1);
    chk("rst_done", {31'd0, Done}, 32'd0);
    CtrlRst = 1'b1;

    run_op(3'd0, 16'hFFFF, 5'd5, 12'h800, 1'b0);
    chk("plan_sll", 32'(ShifterOut), 32'h0000FFE0);
    chk("plan_sll_sext", 32'(SignExtOut), 32'h0000F800);
    run_op(3'd2, 16'h8000, 5'd15, 12'h123, 1'b0);
    run_op(3'd2, 16'h8000, 5'd31, 12'h7FF, 1'b0);
    chk("plan_sra_clamp", 32'(ShifterOut), 32'h0000FFFF);
    run_op(3'd1, 16'hFFFF, 5'd20, 12'hABC, 1'b0);
    run_op(3'd4, 16'h1234, 5'd20, 12'h001, 1'b0);
    chk("plan_ror", 32'(ShifterOut), 32'h00004123);
    run_op(3'd5, 16'hBEEF, 5'd9, 12'hFFF, 1'b0);
    run_op(3'd0, 16'hBEEF, 5'd0, 12'h000, 1'b0);
    run_op(3'd2, 16'h8000, 5'd15, 12'h555, 1'b1);
    run_op(3'd3, 16'h8001, 5'd13, 12'hAAA, 1'b1);

    // back-to-back with Start held high
    @(negedge CLK);
    Start = 1'b1; Mode = 3'd0; ShifterIn = 16'hFFFF; ShiftAmt = 5'd5; Imm = 12'h800;
    @(posedge CLK); #1;
    Mode = 3'd4; ShifterIn = 16'h1234; ShiftAmt = 5'd20; Imm = 12'h321;
    wait_done("b2b_a", c);
    chk("b2b_a_lat", 32'(c), 32'd3);
    chk("b2b_a_res", 32'(ShifterOut), 32'h0000FFE0);
    chk("b2b_a_ready", {31'd0, Ready}, 32'd1);
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_done("b2b_b", c);
    chk("b2b_b_lat", 32'(c), 32'd2);
    chk("b2b_b_res", 32'(ShifterOut), 32'h00004123);
    chk("b2b_b_zext", 32'(ZeroExtOut), 32'h00000321);

    // reset in the middle of a long shift
    @(negedge CLK);
    Start = 1'b1; Mode = 3'd1; ShifterIn = 16'hFFFF; ShiftAmt = 5'd20; Imm = 12'hFFF;
    @(posedge CLK); #1;
    Start = 1'b0;
    @(posedge CLK); #1;
    CtrlRst = 1'b0;
    @(posedge CLK); #1;
    chk("mid_rst_out", 32'(ShifterOut), 32'd0);
    chk("mid_rst_zext", 32'(ZeroExtOut), 32'd0);
    chk("mid_rst_sext", 32'(SignExtOut), 32'd0);
    chk("mid_rst_ready", {31'd0, Ready}, 32'd1);
    chk("mid_rst_done", {31'd0, Done}, 32'd0);
    CtrlRst = 1'b1;
    repeat (6) begin
      @(posedge CLK); #1;
      chk("post_rst_idle", {31'd0, Done}, 32'd0);
    end
    run_op(3'd3, 16'h1234, 5'd4, 12'h0F0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rm = 3'($urandom_range(0, 7));
      run_op(rm, 16'($urandom()), 5'($urandom_range(0, 31)), 12'($urandom()),
             ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iterative_shift_unit.md
Name: iterative_shift_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle stage-4 shifter/extender datapath.
- Shifts or rotates a WIDTH-bit operand by up to STEP bits per cycle, under a Start/Done handshake.
- Registers zero- and sign-extended copies of the instruction immediate alongside the result.
- Sits between the IR/operand registers and the result register; the control unit drives Start/Mode and waits for Done.

Parameters:
- WIDTH, 16, operand/result width (power of two, >= 8).
- STEP, 4, maximum bits shifted per cycle (1..WIDTH).
- IMM_W, 12, immediate width (< WIDTH).
- AMT_W, 5, shift-amount input width (>= log2(WIDTH)+1).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- CtrlRst  in  1  synchronous active-low reset; 0 = reset, sampled on the rising edge of CLK.
- Start  in  1  request; accepted only when Ready=1.
- Mode  in  3  0=SLL, 1=SRL, 2=SRA, 3=ROL, 4=ROR, 5..7=PASS.
- ShifterIn  in  WIDTH  operand.
- ShiftAmt  in  AMT_W  unsigned shift amount.
- Imm  in  IMM_W  immediate field from IR.
- ShifterOut  out  WIDTH  result; held until the next accept.
- ZeroExtOut  out  WIDTH  zero-extended Imm, latched at accept.
- SignExtOut  out  WIDTH  sign-extended Imm (Imm[IMM_W-1] replicated), latched at accept.
- Ready  out  1  high in IDLE and DONE.
- Done  out  1  one-cycle pulse when ShifterOut is valid.

Behaviour:
- Reset (CtrlRst=0 at an edge, including mid-operation):
  - state=IDLE.
  - ShifterOut, ZeroExtOut, SignExtOut, internal remaining count all cleared to 0.
  - Done=0, Ready=1.
  - Any in-flight operation is discarded.
- FSM states: IDLE, SHIFT, DONE.
- Accept (Start=1 and state in {IDLE, DONE}):
  - Latch ShifterIn into the working register and latch Mode.
  - Latch ZeroExtOut/SignExtOut from Imm.
  - Compute the effective amount eff:
    - SLL/SRL: min(ShiftAmt, WIDTH).
    - SRA: min(ShiftAmt, WIDTH-1).
    - ROL/ROR: ShiftAmt mod WIDTH.
    - PASS: 0.
  - remaining=eff. Go to SHIFT if eff>0, else DONE.
- SHIFT: each edge shifts the working register by k=min(STEP, remaining) and sets remaining-=k.
  - SLL fills with 0. SRL fills with 0. SRA fills with the sign bit. ROL/ROR rotate.
  - Go to DONE on the edge where remaining reaches 0.
- DONE:
  - Done=1 for exactly one cycle; ShifterOut equals the final working value.
  - Next state is IDLE, or a new accept if Start=1.
- Latency: n=ceil(eff/STEP). Counting the accept cycle as cycle 0, Done is high in cycle n+1.
- Start while in SHIFT is ignored: no latch, no error, and the current operation completes unaffected.
- Back-to-back: Start held high gives one accept per DONE cycle, with no IDLE bubble.
- ShifterOut changes only on the DONE-entry edge (becomes the final result) and on reset. It does not change at accept or during SHIFT.
- Width rules: ShiftAmt is unsigned. Results are computed modulo 2^WIDTH with no overflow flags.

Decomposition:
- shift_pkg holds:
  - Mode encoding constants (MODE_SLL..MODE_PASS).
  - FSM state encoding.
  - A function returning eff from mode and amount.
- One sub-module, shift_step: a combinational single-step shifter by 0..STEP bits for all modes, instantiated once in the datapath.
- FSM, counter and registers stay in iterative_shift_unit.

Test Plan (WIDTH=16, STEP=4, IMM_W=12):
- SLL, ShifterIn=0xFFFF, ShiftAmt=5, Imm=0x800 -> ShifterOut=0xFFE0, ZeroExtOut=0x0800, SignExtOut=0xF800, Done in cycle 3.
- SRA, 0x8000, amt=15 -> 0xFFFF, Done cycle 5. SRA, 0x8000, amt=31 -> 0xFFFF (clamped), Done cycle 5.
- SRL, 0xFFFF, amt=20 -> 0x0000 (eff=16), Done cycle 5. ROR, 0x1234, amt=20 -> 0x4123 (eff=4), Done cycle 2.
- PASS mode or amt=0, 0xBEEF -> ShifterOut=0xBEEF, Done cycle 1.
- Start re-pulsed during SHIFT with different operand -> ignored; original result delivered. Start held high -> a second accept in the DONE cycle, Ready never low in DONE.
- CtrlRst=0 during SHIFT -> next cycle all outputs 0, Ready=1, Done=0. A new Start after release completes correctly.
